// File: rtl/bilinear_coord_gen_pkg.sv
// Shared constants, fixed-point defaults and FSM encoding for the bilinear
// coordinate generator and its weight calculator.
package bilinear_coord_gen_pkg;

   localparam int unsigned Q_FRAC     = 5;
   localparam int unsigned Q_WIDTH    = 16;
   localparam int unsigned Q_ONE      = 1 << Q_FRAC;
   localparam int unsigned DEF_DIM_W  = 10;
   localparam int unsigned DEF_ADDR_W = 20;

   typedef logic [Q_WIDTH-1:0] q_t;
   typedef logic [Q_FRAC-1:0]  q_frac_t;

   typedef enum logic {
      StIdle = 1'b0,
      StRun  = 1'b1
   } state_e;

   // Integer part of a Q value at the default format.
   function automatic logic [Q_WIDTH-Q_FRAC-1:0] q_int(input q_t v);
      return v[Q_WIDTH-1:Q_FRAC];
   endfunction

   function automatic q_frac_t q_frac(input q_t v);
      return v[Q_FRAC-1:0];
   endfunction

endpackage

// File: rtl/bilinear_weight_calc.sv
// Combinational bilinear weights from the fractional row/column offsets.
// Truncation residue is folded into m3 so the four weights always sum to 1.0.
module bilinear_weight_calc
   import bilinear_coord_gen_pkg::*;
#(
   parameter int unsigned FRAC  = Q_FRAC,
   parameter int unsigned WIDTH = Q_WIDTH
) (
   input  logic [FRAC-1:0]  dr,
   input  logic [FRAC-1:0]  dc,
   output logic [WIDTH-1:0] m3,
   output logic [WIDTH-1:0] m4,
   output logic [WIDTH-1:0] m5,
   output logic [WIDTH-1:0] m6
);

   localparam int unsigned     PW    = 2 * FRAC + 2;
   localparam logic [PW-1:0]   ONE_P = PW'(1) << FRAC;

   logic [PW-1:0] dr_p;
   logic [PW-1:0] dc_p;
   logic [PW-1:0] p4;
   logic [PW-1:0] p5;
   logic [PW-1:0] p6;

   always_comb begin
      dr_p = PW'(dr);
      dc_p = PW'(dc);
      p6   = (dr_p * dc_p) >> FRAC;
      p4   = (dr_p * (ONE_P - dc_p)) >> FRAC;
      p5   = ((ONE_P - dr_p) * dc_p) >> FRAC;
      m6   = WIDTH'(p6);
      m4   = WIDTH'(p4);
      m5   = WIDTH'(p5);
      m3   = WIDTH'(ONE_P - p4 - p5 - p6);
   end

endmodule

// File: rtl/bilinear_coord_gen.sv
// Walks the destination raster, maps each pixel to a clamped source position and
// emits four neighbour addresses plus weights through a 2-stage stallable pipeline.
module bilinear_coord_gen
   import bilinear_coord_gen_pkg::*;
#(
   parameter int unsigned FRAC   = Q_FRAC,
   parameter int unsigned WIDTH  = Q_WIDTH,
   parameter int unsigned DIM_W  = DEF_DIM_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DIM_W-1:0]  src_w,
   input  logic [DIM_W-1:0]  src_h,
   input  logic [DIM_W-1:0]  dst_w,
   input  logic [DIM_W-1:0]  dst_h,
   input  logic [WIDTH-1:0]  step_c,
   input  logic [WIDTH-1:0]  step_r,
   output logic              busy,
   output logic              done,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic [ADDR_W-1:0] addr0,
   output logic [ADDR_W-1:0] addr1,
   output logic [ADDR_W-1:0] addr2,
   output logic [ADDR_W-1:0] addr3,
   output logic [WIDTH-1:0]  m3,
   output logic [WIDTH-1:0]  m4,
   output logic [WIDTH-1:0]  m5,
   output logic [WIDTH-1:0]  m6
);

   localparam int unsigned IW = WIDTH - FRAC;
   localparam int unsigned CW = (IW > DIM_W) ? IW : DIM_W;

   state_e state_q, state_d;
   logic   start_acc;
   logic   en;
   logic   hs_last;

   logic [DIM_W-1:0] src_w_q, src_h_q, dst_w_q, dst_h_q;
   logic [WIDTH-1:0] step_c_q, step_r_q;
   logic [DIM_W-1:0] col_q, row_q;
   logic [WIDTH-1:0] pos_c_q, pos_r_q;
   logic             gen_q;

   logic [DIM_W-1:0]  x_max, y_max;
   logic [IW-1:0]     x_raw, y_raw;
   logic [DIM_W-1:0]  x0, x1, y0, y1;
   logic [FRAC-1:0]   dc, dr;
   logic [ADDR_W-1:0] base0, base1;
   logic              last_pix;

   logic              s1_valid_q, s1_last_q;
   logic [DIM_W-1:0]  s1_x0_q, s1_x1_q;
   logic [ADDR_W-1:0] s1_base0_q, s1_base1_q;
   logic [FRAC-1:0]   s1_dc_q, s1_dr_q;

   logic [WIDTH-1:0]  w3, w4, w5, w6;

   // The whole pipeline moves together; a held output freezes everything upstream.
   assign en      = !out_valid || out_ready;
   assign hs_last = out_valid && out_ready && out_last;
   assign busy    = (state_q == StRun);

   always_comb begin
      state_d   = state_q;
      start_acc = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d   = StRun;
               start_acc = 1'b1;
            end
         end
         StRun: begin
            if (hs_last) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Stage 0: integer/fraction split, edge clamp and row base.
   always_comb begin
      x_max    = src_w_q - 1'b1;
      y_max    = src_h_q - 1'b1;
      x_raw    = pos_c_q[WIDTH-1:FRAC];
      y_raw    = pos_r_q[WIDTH-1:FRAC];
      dc       = pos_c_q[FRAC-1:0];
      dr       = pos_r_q[FRAC-1:0];
      x0       = (CW'(x_raw) > CW'(x_max)) ? x_max : DIM_W'(x_raw);
      y0       = (CW'(y_raw) > CW'(y_max)) ? y_max : DIM_W'(y_raw);
      x1       = (x0 < x_max) ? x0 + 1'b1 : x_max;
      y1       = (y0 < y_max) ? y0 + 1'b1 : y_max;
      base0    = ADDR_W'(y0) * ADDR_W'(src_w_q);
      base1    = (y1 != y0) ? base0 + ADDR_W'(src_w_q) : base0;
      last_pix = (col_q == dst_w_q - 1'b1) && (row_q == dst_h_q - 1'b1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         done    <= hs_last;
      end
   end

   // Raster walk; column position restarts each row, row position accumulates.
   always_ff @(posedge clk) begin
      if (rst) begin
         src_w_q  <= '0;
         src_h_q  <= '0;
         dst_w_q  <= '0;
         dst_h_q  <= '0;
         step_c_q <= '0;
         step_r_q <= '0;
         col_q    <= '0;
         row_q    <= '0;
         pos_c_q  <= '0;
         pos_r_q  <= '0;
         gen_q    <= 1'b0;
      end else if (start_acc) begin
         src_w_q  <= src_w;
         src_h_q  <= src_h;
         dst_w_q  <= dst_w;
         dst_h_q  <= dst_h;
         step_c_q <= step_c;
         step_r_q <= step_r;
         col_q    <= '0;
         row_q    <= '0;
         pos_c_q  <= '0;
         pos_r_q  <= '0;
         gen_q    <= 1'b1;
      end else if (gen_q && en) begin
         if (col_q == dst_w_q - 1'b1) begin
            col_q   <= '0;
            pos_c_q <= '0;
            if (row_q == dst_h_q - 1'b1) begin
               gen_q <= 1'b0;
            end else begin
               row_q   <= row_q + 1'b1;
               pos_r_q <= pos_r_q + step_r_q;
            end
         end else begin
            col_q   <= col_q + 1'b1;
            pos_c_q <= pos_c_q + step_c_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_x0_q    <= '0;
         s1_x1_q    <= '0;
         s1_base0_q <= '0;
         s1_base1_q <= '0;
         s1_dc_q    <= '0;
         s1_dr_q    <= '0;
      end else if (en) begin
         s1_valid_q <= gen_q;
         s1_last_q  <= gen_q && last_pix;
         s1_x0_q    <= x0;
         s1_x1_q    <= x1;
         s1_base0_q <= base0;
         s1_base1_q <= base1;
         s1_dc_q    <= dc;
         s1_dr_q    <= dr;
      end
   end

   bilinear_weight_calc #(
      .FRAC  (FRAC),
      .WIDTH (WIDTH)
   ) u_weight (
      .dr (s1_dr_q),
      .dc (s1_dc_q),
      .m3 (w3),
      .m4 (w4),
      .m5 (w5),
      .m6 (w6)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         addr0     <= '0;
         addr1     <= '0;
         addr2     <= '0;
         addr3     <= '0;
         m3        <= '0;
         m4        <= '0;
         m5        <= '0;
         m6        <= '0;
      end else if (en) begin
         out_valid <= s1_valid_q;
         out_last  <= s1_last_q;
         addr0     <= s1_base0_q + ADDR_W'(s1_x0_q);
         addr1     <= s1_base1_q + ADDR_W'(s1_x0_q);
         addr2     <= s1_base0_q + ADDR_W'(s1_x1_q);
         addr3     <= s1_base1_q + ADDR_W'(s1_x1_q);
         m3        <= w3;
         m4        <= w4;
         m5        <= w5;
         m6        <= w6;
      end
   end

endmodule

// File: tb/tb_bilinear_coord_gen.sv
// Self-checking bench: a per-pixel reference model fills a queue of expected beats,
// and one negedge process checks every handshake, stall hold and done pulse.
module tb_bilinear_coord_gen;
   import bilinear_coord_gen_pkg::*;

   typedef struct packed {
      logic [19:0] a0;
      logic [19:0] a1;
      logic [19:0] a2;
      logic [19:0] a3;
      logic [15:0] m3;
      logic [15:0] m4;
      logic [15:0] m5;
      logic [15:0] m6;
      logic        last;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [9:0]  src_w = '0, src_h = '0, dst_w = '0, dst_h = '0;
   logic [15:0] step_c = '0, step_r = '0;
   logic        busy, done, out_valid, out_last;
   logic        out_ready = 1'b1;
   logic [19:0] addr0, addr1, addr2, addr3;
   logic [15:0] m3, m4, m5, m6;

   int    n_cmp = 0;
   int    n_fail = 0;
   int    total_beats = 0;
   beat_t exp_q[$];
   beat_t held;
   bit    stall_q = 1'b0;
   bit    done_exp = 1'b0;

   always #5 clk = ~clk;

   bilinear_coord_gen dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .src_w     (src_w),
      .src_h     (src_h),
      .dst_w     (dst_w),
      .dst_h     (dst_h),
      .step_c    (step_c),
      .step_r    (step_r),
      .busy      (busy),
      .done      (done),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .addr0     (addr0),
      .addr1     (addr1),
      .addr2     (addr2),
      .addr3     (addr3),
      .m3        (m3),
      .m4        (m4),
      .m5        (m5),
      .m6        (m6)
   );

   function automatic beat_t mk(int a0, int a1, int a2, int a3,
                                int w3, int w4, int w5, int w6, bit last);
      beat_t b;
      b.a0 = 20'(a0); b.a1 = 20'(a1); b.a2 = 20'(a2); b.a3 = 20'(a3);
      b.m3 = 16'(w3); b.m4 = 16'(w4); b.m5 = 16'(w5); b.m6 = 16'(w6);
      b.last = last;
      return b;
   endfunction

   // Reference: source position = index * step, split into integer/fraction, clamp.
   function automatic beat_t model_px(int sw, int sh, int stc, int str, int r, int c, bit last);
      int pc, pr, x0, x1, y0, y1, dc, dr, w4, w5, w6;
      pc = (c * stc) % 65536;
      pr = (r * str) % 65536;
      x0 = pc / 32; dc = pc % 32;
      y0 = pr / 32; dr = pr % 32;
      if (x0 > sw - 1) x0 = sw - 1;
      if (y0 > sh - 1) y0 = sh - 1;
      x1 = (x0 + 1 > sw - 1) ? sw - 1 : x0 + 1;
      y1 = (y0 + 1 > sh - 1) ? sh - 1 : y0 + 1;
      w6 = (dr * dc) / 32;
      w4 = (dr * (32 - dc)) / 32;
      w5 = ((32 - dr) * dc) / 32;
      return mk(y0 * sw + x0, y1 * sw + x0, y0 * sw + x1, y1 * sw + x1,
                32 - w4 - w5 - w6, w4, w5, w6, last);
   endfunction

   task automatic build_frame(int sw, int sh, int dw, int dh, int stc, int str);
      exp_q.delete();
      for (int r = 0; r < dh; r++)
         for (int c = 0; c < dw; c++)
            exp_q.push_back(model_px(sw, sh, stc, str, r, c, (r == dh - 1) && (c == dw - 1)));
   endtask

   task automatic check_beat(string nm, beat_t got, beat_t want);
      n_cmp++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got=%h want=%h", nm, got, want);
      end
   endtask

   task automatic check_int(string nm, int got, int want);
      n_cmp++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s got=%0d want=%0d", nm, got, want);
      end
   endtask

   task automatic check_zero(string nm);
      logic [147:0] v;
      v = {out_valid, out_last, busy, done, addr0, addr1, addr2, addr3, m3, m4, m5, m6};
      n_cmp++;
      if (v !== '0) begin
         n_fail++;
         $display("FAIL %s got=%h want=0", nm, v);
      end
   endtask

   always @(negedge clk) begin
      beat_t cur;
      cur = {addr0, addr1, addr2, addr3, m3, m4, m5, m6, out_last};
      if (rst) begin
         stall_q  = 1'b0;
         done_exp = 1'b0;
      end else begin
         if (stall_q) begin
            check_int("stall_valid", int'(out_valid), 1);
            check_beat("stall_hold", cur, held);
         end
         check_int("done_pulse", int'(done), int'(done_exp));
         done_exp = 1'b0;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check_int("unexpected_beat", 1, 0);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               check_beat("beat", cur, e);
               done_exp = e.last;
            end
            total_beats++;
         end
         stall_q = out_valid && !out_ready;
         held    = cur;
      end
   end

   task automatic start_frame(int sw, int sh, int dw, int dh, int stc, int str);
      @(posedge clk); #1;
      src_w = 10'(sw); src_h = 10'(sh); dst_w = 10'(dw); dst_h = 10'(dh);
      step_c = 16'(stc); step_r = 16'(str);
      out_ready = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check_int("busy_after_start", int'(busy), 1);
      check_int("valid_at_1", int'(out_valid), 0);
      @(posedge clk); #1;
      check_int("valid_at_1b", int'(out_valid), 0);
      @(posedge clk); #1;
      check_int("valid_at_2", int'(out_valid), 1);
   endtask

   // mode 0: ready high; 1: 5-cycle drop mid-row; 2: ready pattern + start held
   // with junk parameters; 3: assert reset once 20 beats are out.
   task automatic run_frame(int mode, int budget, int want_beats);
      int base, drop_left, cyc;
      bit seen;
      base = total_beats; drop_left = 5; cyc = 0; seen = 1'b0;
      while (cyc < budget) begin
         case (mode)
            1: begin
               if (total_beats - base >= 3 && drop_left > 0) begin
                  out_ready = 1'b0;
                  drop_left--;
               end else begin
                  out_ready = 1'b1;
               end
            end
            2: begin
               out_ready = (cyc % 3 != 2);
               start = 1'b1;
               src_w = 10'd7; dst_w = 10'd2; step_c = 16'd5;
            end
            default: out_ready = 1'b1;
         endcase
         if (mode == 3 && total_beats - base >= 20) begin
            rst = 1'b1;
            return;
         end
         @(posedge clk); #1;
         cyc++;
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      start = 1'b0;
      out_ready = 1'b1;
      check_int("done_seen", int'(seen), 1);
      check_int("beat_count", total_beats - base, want_beats);
      check_int("queue_drained", exp_q.size(), 0);
      check_int("idle_after_done", int'(busy), 0);
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset_state");
      rst = 1'b0;

      // Upscale 4x4 -> 8x8 at step 0.5, with a backpressure window.
      build_frame(4, 4, 8, 8, 16, 16);
      check_beat("model_px00", exp_q[0], mk(0, 4, 1, 5, 32, 0, 0, 0, 1'b0));
      check_beat("model_px01", exp_q[1], mk(0, 4, 1, 5, 16, 0, 16, 0, 1'b0));
      check_beat("model_px11", exp_q[9], mk(0, 4, 1, 5, 8, 8, 8, 8, 1'b0));
      check_beat("model_px77", exp_q[63], mk(15, 15, 15, 15, 8, 8, 8, 8, 1'b1));
      start_frame(4, 4, 8, 8, 16, 16);
      run_frame(1, 400, 64);

      // Identity 5x3; start held high throughout, including the final handshake.
      build_frame(5, 3, 5, 3, 32, 32);
      check_beat("model_id7", exp_q[7], mk(7, 12, 8, 13, 32, 0, 0, 0, 1'b0));
      check_beat("model_id14", exp_q[14], mk(14, 14, 14, 14, 32, 0, 0, 0, 1'b1));
      start_frame(5, 3, 5, 3, 32, 32);
      run_frame(2, 400, 15);
      repeat (3) begin
         @(posedge clk); #1;
         check_int("stay_idle_valid", int'(out_valid), 0);
         check_int("stay_idle_busy", int'(busy), 0);
      end

      // Abort mid-frame, then a clean full frame.
      build_frame(4, 4, 8, 8, 16, 16);
      start_frame(4, 4, 8, 8, 16, 16);
      run_frame(3, 400, 0);
      exp_q.delete();
      @(posedge clk); #1;
      check_zero("after_abort");
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_int("abort_no_done", int'(done), 0);
      build_frame(4, 4, 8, 8, 16, 16);
      start_frame(4, 4, 8, 8, 16, 16);
      run_frame(0, 400, 64);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
